truth_table_sweeper: RTL

Sequential stimulus-and-capture stage sitting directly upstream of the combinational gate modules (implication `~x | y`, exclusive-or `x ^ y`). On `start` it walks every input combination, holds each vector on `x_out` for a settle window, and samples the gate outputs back on `res_in`. It packs the sampled values into a result table and compares them against an expected table, replacing the hand-written `#1` stimulus sequence with a clocked, self-checking sweep.

---
 rtl/sweep_pkg.sv | 19 +
 rtl/settle_timer.sv | 37 +++
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding,
// the default implication/xor expected table and the slot offset helper.
package sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Slot v holds {~x|y, x^y} for x_out = v, packed with slot 0 at the LSBs.
  localparam logic [7:0] EXP_TABLE_IMPL_XOR = 8'h9E;

  function automatic int slot(input int v, input int n_out);
    return v * n_out;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags the last settle cycle of a vector; it stops
// at zero so it idles quietly between loads.
module settle_timer #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(HOLD);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reading 1 means this is the final DRIVE cycle; SAMPLE follows.
  assign expired = (cnt_q == CW'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a combinational gate block, holds each one for a
// settle window, captures the gate outputs into a packed table and counts misses.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter int HOLD = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXP_TABLE = EXP_TABLE_IMPL_XOR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [N_IN-1:0]              x_out,
  input  logic [N_OUT-1:0]             res_in,
  output logic                         busy,
  output logic                         done,
  output logic [(2**N_IN)*N_OUT-1:0]   table_out,
  output logic [$clog2(2**N_IN+1)-1:0] err_cnt,
  output logic                         pass
);

  localparam int NV = 2 ** N_IN;
  localparam int TW = NV * N_OUT;
  localparam int EW = $clog2(NV + 1);
  localparam logic [N_IN-1:0] LAST_V = N_IN'(NV - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] x_q, x_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic [EW-1:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            tmr_load, tmr_en, tmr_expired;

  settle_timer #(.HOLD(HOLD)) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    tbl_d    = tbl_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          tbl_d    = '0;
          err_d    = '0;
          x_d      = '0;
          tmr_load = 1'b1;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        tbl_d[slot(int'(x_q), N_OUT) +: N_OUT] = res_in;
        if (res_in != EXP_TABLE[slot(int'(x_q), N_OUT) +: N_OUT]) begin
          err_d = err_q + EW'(1);
        end
        // The last vector ends the sweep, so x_out never wraps.
        if (x_q == LAST_V) begin
          state_d = S_DONE;
        end else begin
          x_d      = x_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  assign busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
  assign done_d = (state_d == S_DONE);
  assign pass_d = done_d && (err_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out     = x_q;
  assign table_out = tbl_q;
  assign err_cnt   = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule
